// File: rtl/hash_blk_loader.sv
// hash_blk_loader: byte-serial frame loader in front of the hash core.
// Detects a start code and assembles the following bytes into big-endian
// message blocks. Blocks go to the core through a 2-entry FIFO with
// valid/ready handshaking.
// Build option: HASH_LOADER_MULTI_BLK_EN enables the length byte and
// multi-block frames. Without it, every frame is exactly one block.
//
// state     | meaning
// ST_IDLE   | waiting for START_CODE
// ST_LEN    | sampling frame length in blocks (multi-block build only)
// ST_DATA   | shifting data bytes into the assembly register
module hash_blk_loader #(
    parameter int         BLK_BYTES  = 64,
    parameter int         MAX_BLKS   = 4,
    parameter logic [7:0] START_CODE = 8'hAA,
    parameter int         IDX_W      = (MAX_BLKS > 1) ? $clog2(MAX_BLKS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             i_text,
    output logic [BLK_BYTES*8-1:0] o_blk,
    output logic                   o_blk_valid,
    input  logic                   i_blk_ready,
    output logic                   o_blk_last,
    output logic [IDX_W-1:0]       o_blk_idx,
    output logic                   o_busy,
    output logic                   o_err
);

    localparam int              BLK_W     = BLK_BYTES * 8;
    localparam int              BC_W      = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
    localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(BLK_BYTES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef HASH_LOADER_MULTI_BLK_EN
    localparam logic [1:0] ST_LEN  = 2'd1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_BLKS);
`endif
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]       state;
    logic [BC_W-1:0]  byte_cnt;
    logic [BLK_W-1:0] asm_q;
    logic             err_q;
`ifdef HASH_LOADER_MULTI_BLK_EN
    logic [IDX_W-1:0] blk_cnt;
    logic [IDX_W-1:0] last_idx;
    logic             len_bad;
`endif

    logic [BLK_W-1:0] mem_blk  [2];
    logic             mem_last [2];
    logic [IDX_W-1:0] mem_idx  [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       fifo_cnt;

    logic [BLK_W-1:0] asm_next;
    logic             commit;
    logic             commit_last;
    logic [IDX_W-1:0] commit_idx;
    logic             head_valid;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             ovf;

    // Commit/handshake decode; the committed block includes the byte sampled this cycle
    always_comb begin
        asm_next   = {asm_q[BLK_W-9:0], i_text};
        commit     = (state == ST_DATA) && (byte_cnt == BYTE_LAST);
        head_valid = (fifo_cnt != 2'd0);
        fifo_full  = (fifo_cnt == 2'd2);
        pop        = head_valid && i_blk_ready;
        push       = commit && (!fifo_full || pop);
        ovf        = commit && fifo_full && !pop;
`ifdef HASH_LOADER_MULTI_BLK_EN
        commit_last = (blk_cnt == last_idx);
        commit_idx  = blk_cnt;
        len_bad     = (i_text == 8'd0) || (i_text > MAX_LEN);
`else
        commit_last = 1'b1;
        commit_idx  = '0;
`endif
    end

    // Frame FSM: start detect, length capture, byte/block counting, sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            asm_q    <= '0;
            err_q    <= 1'b0;
`ifdef HASH_LOADER_MULTI_BLK_EN
            blk_cnt  <= '0;
            last_idx <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_text == START_CODE) begin
                        byte_cnt <= '0;
`ifdef HASH_LOADER_MULTI_BLK_EN
                        state    <= ST_LEN;
`else
                        state    <= ST_DATA;
`endif
                    end
                end
`ifdef HASH_LOADER_MULTI_BLK_EN
                ST_LEN: begin
                    if (len_bad) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        last_idx <= IDX_W'(i_text - 8'd1);
                        byte_cnt <= '0;
                        blk_cnt  <= '0;
                        state    <= ST_DATA;
                    end
                end
`endif
                ST_DATA: begin
                    asm_q <= asm_next;
                    if (commit) begin
                        byte_cnt <= '0;
                        if (ovf) begin
                            // Drop the block and abandon the frame; queued blocks stay
                            err_q <= 1'b1;
                            state <= ST_IDLE;
                        end else if (commit_last) begin
                            state <= ST_IDLE;
                        end else begin
`ifdef HASH_LOADER_MULTI_BLK_EN
                            blk_cnt <= blk_cnt + IDX_W'(1);
`endif
                        end
                    end else begin
                        byte_cnt <= byte_cnt + BC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Two-entry block FIFO; a pop in the same cycle makes room for a push when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_blk[i]  <= '0;
                mem_last[i] <= 1'b0;
                mem_idx[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_blk[wr_ptr]  <= asm_next;
                mem_last[wr_ptr] <= commit_last;
                mem_idx[wr_ptr]  <= commit_idx;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign o_blk       = mem_blk[rd_ptr];
    assign o_blk_valid = head_valid;
    assign o_blk_last  = head_valid & mem_last[rd_ptr];
    assign o_blk_idx   = head_valid ? mem_idx[rd_ptr] : '0;
    assign o_busy      = (state != ST_IDLE) || head_valid;
    assign o_err       = err_q;

endmodule

// File: tb/tb_hash_blk_loader.sv
// Directed bench for hash_blk_loader (default parameters). Adapts to the
// HASH_LOADER_MULTI_BLK_EN build: length byte and multi-block frames.
module tb_hash_blk_loader;

    localparam int BLK = 64;
`ifdef HASH_LOADER_MULTI_BLK_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [7:0]       i_text;
    logic [BLK*8-1:0] o_blk;
    logic             o_blk_valid;
    logic             i_blk_ready;
    logic             o_blk_last;
    logic [1:0]       o_blk_idx;
    logic             o_busy;
    logic             o_err;

    int checks = 0;
    int errors = 0;

    hash_blk_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_text      (i_text),
        .o_blk       (o_blk),
        .o_blk_valid (o_blk_valid),
        .i_blk_ready (i_blk_ready),
        .o_blk_last  (o_blk_last),
        .o_blk_idx   (o_blk_idx),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BLK*8-1:0] ramp_blk(input logic [7:0] seed);
        logic [BLK*8-1:0] r;
        r = '0;
        for (int j = 0; j < BLK; j++) r = {r[BLK*8-9:0], seed + 8'(j)};
        return r;
    endfunction

    function automatic logic exp_last(input int k, input int n);
        return MULTI ? (k == n - 1) : 1'b1;
    endfunction

    function automatic logic [1:0] exp_idx(input int k);
        return MULTI ? 2'(k) : 2'd0;
    endfunction

    // Drive a byte between edges; return just after the edge that samples it
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_text = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input int n);
        send_byte(8'hAA);
        if (MULTI) send_byte(8'(n));
    endtask

    task automatic send_ramp(input logic [7:0] seed, input int n);
        for (int j = 0; j < n; j++) send_byte(seed + 8'(j));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_text = 8'h00;
        i_blk_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_blk !== '0) begin errors++; $display("FAIL reset_blk: got %h want 0", o_blk); end
        checks++; if (o_blk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_blk_valid); end
        checks++; if (o_blk_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", o_blk_last); end
        checks++; if (o_blk_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", o_blk_idx); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", o_err); end
    endtask

    task automatic test_single();
        do_reset();
        i_blk_ready = 1'b1;
        send_byte(8'h00);
        send_byte(8'h00);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", o_busy); end
        send_hdr(1);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_hdr_busy: got %b want 1", o_busy); end
        send_ramp(8'h00, BLK - 1);
        checks++; if (o_blk_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", o_blk_valid); end
        send_byte(8'h3F);
        checks++; if (o_blk_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", o_blk_valid); end
        checks++; if (o_blk !== ramp_blk(8'h00)) begin errors++; $display("FAIL single_blk: got %h want %h", o_blk, ramp_blk(8'h00)); end
        checks++; if (o_blk_last !== 1'b1) begin errors++; $display("FAIL single_last: got %b want 1", o_blk_last); end
        checks++; if (o_blk_idx !== 2'd0) begin errors++; $display("FAIL single_idx: got %0d want 0", o_blk_idx); end
        send_byte(8'h00);
        checks++; if (o_blk_valid !== 1'b0) begin errors++; $display("FAIL single_popped: got %b want 0", o_blk_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_done_busy: got %b want 0", o_busy); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", o_err); end
    endtask

    task automatic test_multi();
        logic [7:0] seed;
        do_reset();
        i_blk_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 0 || !MULTI) send_hdr(3);
            seed = 8'h10 + 8'(k * BLK);
            send_ramp(seed, BLK);
            checks++; if (o_blk_valid !== 1'b1) begin errors++; $display("FAIL multi_valid[%0d]: got %b want 1", k, o_blk_valid); end
            checks++; if (o_blk !== ramp_blk(seed)) begin errors++; $display("FAIL multi_blk[%0d]: got %h want %h", k, o_blk, ramp_blk(seed)); end
            checks++; if (o_blk_idx !== exp_idx(k)) begin errors++; $display("FAIL multi_idx[%0d]: got %0d want %0d", k, o_blk_idx, exp_idx(k)); end
            checks++; if (o_blk_last !== exp_last(k, 3)) begin errors++; $display("FAIL multi_last[%0d]: got %b want %b", k, o_blk_last, exp_last(k, 3)); end
        end
        send_byte(8'h00);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL multi_end_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_embedded();
        logic [BLK*8-1:0] exp_blk;
        logic [7:0]       b;
        do_reset();
        i_blk_ready = 1'b1;
        exp_blk = '0;
        send_hdr(1);
        for (int j = 0; j < BLK; j++) begin
            b = (j % 4 == 0) ? 8'hAA : 8'(j);
            exp_blk = {exp_blk[BLK*8-9:0], b};
            send_byte(b);
        end
        checks++; if (o_blk_valid !== 1'b1) begin errors++; $display("FAIL embed_valid: got %b want 1", o_blk_valid); end
        checks++; if (o_blk !== exp_blk) begin errors++; $display("FAIL embed_blk: got %h want %h", o_blk, exp_blk); end
    endtask

    task automatic test_overflow();
        int drift;
        do_reset();
        send_hdr(3);
        send_ramp(8'h20, BLK);
        checks++; if (o_blk_valid !== 1'b1) begin errors++; $display("FAIL ovf_first_valid: got %b want 1", o_blk_valid); end
        drift = 0;
        if (!MULTI) send_hdr(3);
        for (int j = 0; j < BLK; j++) begin
            send_byte(8'h60 + 8'(j));
            if (o_blk !== ramp_blk(8'h20) || o_blk_idx !== 2'd0 || o_blk_valid !== 1'b1) drift++;
        end
        checks++; if (drift !== 0) begin errors++; $display("FAIL ovf_hold_stable: got %0d changed cycles want 0", drift); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %b want 0", o_err); end
        if (!MULTI) send_hdr(3);
        send_ramp(8'hA0, BLK);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", o_err); end
        checks++; if (o_blk !== ramp_blk(8'h20)) begin errors++; $display("FAIL ovf_head_kept: got %h want %h", o_blk, ramp_blk(8'h20)); end
        i_blk_ready = 1'b1;
        send_byte(8'h00);
        checks++; if (o_blk !== ramp_blk(8'h60)) begin errors++; $display("FAIL ovf_second: got %h want %h", o_blk, ramp_blk(8'h60)); end
        checks++; if (o_blk_idx !== exp_idx(1)) begin errors++; $display("FAIL ovf_second_idx: got %0d want %0d", o_blk_idx, exp_idx(1)); end
        checks++; if (o_blk_last !== exp_last(1, 3)) begin errors++; $display("FAIL ovf_second_last: got %b want %b", o_blk_last, exp_last(1, 3)); end
        send_byte(8'h00);
        checks++; if (o_blk_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", o_blk_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ovf_idle_busy: got %b want 0", o_busy); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %b want 1", o_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_hdr(3);
        send_ramp(8'h01, BLK);
        if (!MULTI) send_hdr(3);
        send_ramp(8'h41, BLK);
        if (!MULTI) send_hdr(3);
        send_ramp(8'h81, BLK - 1);
        i_blk_ready = 1'b1;
        send_byte(8'h81 + 8'(BLK - 1));
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", o_err); end
        checks++; if (o_blk !== ramp_blk(8'h41)) begin errors++; $display("FAIL b2b_head1: got %h want %h", o_blk, ramp_blk(8'h41)); end
        send_byte(8'h00);
        checks++; if (o_blk !== ramp_blk(8'h81)) begin errors++; $display("FAIL b2b_head2: got %h want %h", o_blk, ramp_blk(8'h81)); end
        checks++; if (o_blk_idx !== exp_idx(2)) begin errors++; $display("FAIL b2b_idx2: got %0d want %0d", o_blk_idx, exp_idx(2)); end
        checks++; if (o_blk_last !== 1'b1) begin errors++; $display("FAIL b2b_last2: got %b want 1", o_blk_last); end
        send_byte(8'h00);
        checks++; if (o_blk_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", o_blk_valid); end
    endtask

`ifdef HASH_LOADER_MULTI_BLK_EN
    task automatic test_bad_len();
        do_reset();
        i_blk_ready = 1'b1;
        send_byte(8'hAA);
        send_byte(8'h00);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL badlen0_err: got %b want 1", o_err); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL badlen0_busy: got %b want 0", o_busy); end
        send_byte(8'hAA);
        send_byte(8'h05);
        checks++; if (o_blk_valid !== 1'b0) begin errors++; $display("FAIL badlen5_valid: got %b want 0", o_blk_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL badlen5_busy: got %b want 0", o_busy); end
        send_hdr(1);
        send_ramp(8'hC0, BLK);
        checks++; if (o_blk_valid !== 1'b1) begin errors++; $display("FAIL badlen_next_valid: got %b want 1", o_blk_valid); end
        checks++; if (o_blk !== ramp_blk(8'hC0)) begin errors++; $display("FAIL badlen_next_blk: got %h want %h", o_blk, ramp_blk(8'hC0)); end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        send_hdr(2);
        send_ramp(8'h40, BLK);
        checks++; if (o_blk_valid !== 1'b1) begin errors++; $display("FAIL rstmid_queued: got %b want 1", o_blk_valid); end
        if (!MULTI) send_hdr(2);
        send_ramp(8'h80, 30);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (o_blk_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", o_blk_valid); end
        checks++; if (o_blk !== '0) begin errors++; $display("FAIL rstmid_blk: got %h want 0", o_blk); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        i_blk_ready = 1'b1;
        @(posedge clk);
        #1;
        send_hdr(1);
        send_ramp(8'h33, BLK);
        checks++; if (o_blk !== ramp_blk(8'h33)) begin errors++; $display("FAIL rstmid_clean_blk: got %h want %h", o_blk, ramp_blk(8'h33)); end
        checks++; if (o_blk_last !== 1'b1) begin errors++; $display("FAIL rstmid_clean_last: got %b want 1", o_blk_last); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rstmid_clean_err: got %b want 0", o_err); end
    endtask

    initial begin
        rst_n = 1'b0;
        i_text = 8'h00;
        i_blk_ready = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_embedded();
        test_overflow();
        test_back_to_back();
`ifdef HASH_LOADER_MULTI_BLK_EN
        test_bad_len();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
